// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: port-select constants, response tag layout and default starvation limit for dmem_arbiter
package dmem_arb_pkg;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;
  localparam int STARVE_LIMIT_DEF = 4;
  typedef struct packed {
    logic port;
    logic is_read;
  } rsp_tag_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: cpu/aux request+response ports and RAM port; slave = arbiter side, master = requester/RAM side
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  cpu_valid, cpu_ready, cpu_we, cpu_rsp_valid;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata, cpu_rdata;
  logic                  aux_valid, aux_ready, aux_we, aux_rsp_valid;
  logic [ADDR_WIDTH-1:0] aux_addr;
  logic [DATA_WIDTH-1:0] aux_wdata, aux_rdata;
  logic                  ram_wEn;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_dataIn, ram_dataOut;
  modport slave (
    input  cpu_valid, cpu_we, cpu_addr, cpu_wdata,
    input  aux_valid, aux_we, aux_addr, aux_wdata,
    input  ram_dataOut,
    output cpu_ready, cpu_rsp_valid, cpu_rdata,
    output aux_ready, aux_rsp_valid, aux_rdata,
    output ram_wEn, ram_addr, ram_dataIn
  );
  modport master (
    output cpu_valid, cpu_we, cpu_addr, cpu_wdata,
    output aux_valid, aux_we, aux_addr, aux_wdata,
    output ram_dataOut,
    input  cpu_ready, cpu_rsp_valid, cpu_rdata,
    input  aux_ready, aux_rsp_valid, aux_rdata,
    input  ram_wEn, ram_addr, ram_dataIn
  );
endinterface

// File: rtl/arb_starve_counter.sv
// arb_starve_counter: saturating 4-bit aux-denial counter; ports clk_i, rst_ni, inc_i, clr_i (wins over inc), at_limit_o = cnt >= LIMIT
module arb_starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);
  logic [3:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = clr_i ? 4'd0 : (inc_i && cnt_q != 4'hF) ? cnt_q + 4'd1 : cnt_q;
    at_limit_o = cnt_q >= 4'(LIMIT);
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= 4'd0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: cpu-priority RAM arbiter with aux starvation guard and 1-cycle response; ports clk_i, rst_ni (async, low), bus (dmem_arbiter_if.slave)
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input logic           clk_i,
  input logic           rst_ni,
  dmem_arbiter_if.slave bus
);
  logic                  at_limit, aux_win, cpu_win, grant;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rsp_vld_q, rsp_vld_d;
  rsp_tag_t              tag_q, tag_d;
  arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk_i,
    .rst_ni,
    .inc_i     (bus.aux_valid && cpu_win),
    .clr_i     (aux_win || !bus.aux_valid),
    .at_limit_o(at_limit)
  );
  // Grants are gated by rst_ni so no request is accepted while reset is held.
  always_comb begin
    aux_win = rst_ni && bus.aux_valid && (!bus.cpu_valid || at_limit);
    cpu_win = rst_ni && bus.cpu_valid && !aux_win;
    grant = aux_win || cpu_win;
    addr_d = !grant ? addr_q : aux_win ? bus.aux_addr : bus.cpu_addr;
    wdata_d = !grant ? wdata_q : aux_win ? bus.aux_wdata : bus.cpu_wdata;
    rsp_vld_d = grant;
    tag_d = '{port: aux_win ? PORT_AUX : PORT_CPU, is_read: aux_win ? !bus.aux_we : !bus.cpu_we};
    bus.cpu_ready = cpu_win;
    bus.aux_ready = aux_win;
    bus.ram_wEn = grant && (aux_win ? bus.aux_we : bus.cpu_we);
    bus.ram_addr = addr_d;
    bus.ram_dataIn = wdata_d;
    bus.cpu_rsp_valid = rsp_vld_q && tag_q.port == PORT_CPU;
    bus.aux_rsp_valid = rsp_vld_q && tag_q.port == PORT_AUX;
    bus.cpu_rdata = bus.cpu_rsp_valid && tag_q.is_read ? bus.ram_dataOut : '0;
    bus.aux_rdata = bus.aux_rsp_valid && tag_q.is_read ? bus.ram_dataOut : '0;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      addr_q <= '0;
      wdata_q <= '0;
      rsp_vld_q <= 1'b0;
      tag_q <= '0;
    end else begin
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rsp_vld_q <= rsp_vld_d;
      tag_q <= tag_d;
    end
endmodule
